// File: rtl/bus_arbiter_pkg.sv
// Shared bus constants: active-low enable levels and master indices.
// Imported by the arbiter and its round-robin picker.
package bus_arbiter_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BUS_OWNER_W = 2;
    localparam int BUS_MASTERS = 4;

    typedef logic [BUS_OWNER_W-1:0] owner_t;

    localparam owner_t BUS_MASTER_0 = 2'd0;
    localparam owner_t BUS_MASTER_1 = 2'd1;
    localparam owner_t BUS_MASTER_2 = 2'd2;
    localparam owner_t BUS_MASTER_3 = 2'd3;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Rotating-priority search: first active request from owner+1 .. owner+3.
// The owner's own request bit never takes part in the search.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  owner_t     owner,
    input  logic [3:0] req,
    output owner_t     nxt,
    output logic       valid
);

    owner_t cand;

    always_comb begin
        nxt   = owner;
        valid = 1'b0;
        cand  = owner;
        // Walk from the farthest slot inward so the nearest hit wins.
        for (int i = 3; i >= 1; i--) begin
            cand = owner + owner_t'(i);
            if (req[cand]) begin
                nxt   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master non-preemptive bus arbiter with round-robin handover,
// parking on the last owner and an optional hold limit.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m0_req_,
    input  logic                   m1_req_,
    input  logic                   m2_req_,
    input  logic                   m3_req_,
    output logic                   m0_grnt_,
    output logic                   m1_grnt_,
    output logic                   m2_grnt_,
    output logic                   m3_grnt_,
    output logic [BUS_OWNER_W-1:0] owner,
    output logic                   handover
);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic              LIMIT_ON  = (MAX_HOLD != 0);

    logic [3:0]        req;
    logic [3:0]        grnt_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_d;
    owner_t            owner_d;
    owner_t            pick;
    logic              pick_ok;
    logic              own_req;
    logic              contend;
    logic              force_ho;

    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

    bus_arb_rr_pick u_pick (
        .owner (owner),
        .req   (req),
        .nxt   (pick),
        .valid (pick_ok)
    );

    assign own_req  = req[owner];
    assign contend  = own_req & pick_ok;
    assign force_ho = LIMIT_ON && contend && (hold_cnt == HOLD_LAST);

    always_comb begin
        owner_d = owner;
        hold_d  = '0;
        if (pick_ok && (!own_req || force_ho)) begin
            owner_d = pick;
        end
        // Count only while the same owner holds against a waiting master.
        if (owner_d == owner && contend) begin
            hold_d = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= BUS_MASTER_0;
            hold_cnt <= '0;
            handover <= 1'b0;
            grnt_q   <= {DISABLE_, DISABLE_, DISABLE_, ENABLE_};
        end else begin
            owner    <= owner_d;
            hold_cnt <= hold_d;
            handover <= (owner_d != owner);
            // Grant flops mirror the owner register, one-cold decoded.
            grnt_q   <= ~(4'b0001 << owner_d);
        end
    end

    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: one arbiter with MAX_HOLD=4, one with the limit disabled,
// both driven by the same request vector.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_n;

    logic [3:0] g4;
    logic [3:0] g0;
    logic [1:0] own4;
    logic [1:0] own0;
    logic       ho4;
    logic       ho0;
    logic       armed = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) u_h4 (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (req_n[0]),
        .m1_req_  (req_n[1]),
        .m2_req_  (req_n[2]),
        .m3_req_  (req_n[3]),
        .m0_grnt_ (g4[0]),
        .m1_grnt_ (g4[1]),
        .m2_grnt_ (g4[2]),
        .m3_grnt_ (g4[3]),
        .owner    (own4),
        .handover (ho4)
    );

    bus_arbiter #(.MAX_HOLD(0), .HOLD_W(5)) u_h0 (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (req_n[0]),
        .m1_req_  (req_n[1]),
        .m2_req_  (req_n[2]),
        .m3_req_  (req_n[3]),
        .m0_grnt_ (g0[0]),
        .m1_grnt_ (g0[1]),
        .m2_grnt_ (g0[2]),
        .m3_grnt_ (g0[3]),
        .owner    (own0),
        .handover (ho0)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exactly one grant low on every cycle, for both instances.
    always @(negedge clk) begin
        if (armed) begin
            chk("onehot_g4", int'($onehot(~g4)), 1);
            chk("onehot_g0", int'($onehot(~g0)), 1);
        end
    end

    initial begin
        reset = 1'b1;
        req_n = 4'hF;
        tick();
        armed = 1'b1;
        tick();
        chk("rst_owner", own4, 0);
        chk("rst_grnt", g4, 4'b1110);
        chk("rst_ho", ho4, 0);
        chk("rst_hold", u_h4.hold_cnt, 0);
        chk("rst_owner0", own0, 0);

        reset = 1'b0;
        tick();
        chk("idle_owner", own4, 0);
        chk("idle_ho", ho4, 0);

        // Park -> m2 request, one-cycle latency.
        req_n = 4'b1011;
        tick();
        chk("park_owner", own4, 2);
        chk("park_grnt", g4, 4'b1011);
        chk("park_ho", ho4, 1);
        tick();
        chk("park_owner2", own4, 2);
        chk("park_ho2", ho4, 0);

        // Rotation: 2 -> 1, then 1 -> 2 -> 3 -> 0.
        req_n = 4'b1101;
        tick();
        chk("rot_to1", own4, 1);
        chk("rot_to1_ho", ho4, 1);
        req_n = 4'b0010;
        tick();
        chk("rot_to2", own4, 2);
        chk("rot_to2_grnt", g4, 4'b1011);
        chk("rot_to2_ho", ho4, 1);
        req_n = 4'b0110;
        tick();
        chk("rot_to3", own4, 3);
        chk("rot_to3_grnt", g4, 4'b0111);
        req_n = 4'b1110;
        tick();
        chk("rot_to0", own4, 0);
        chk("rot_to0_ho", ho4, 1);

        // All idle: owner held, counter clear, no pulse.
        req_n = 4'hF;
        tick();
        chk("allidle_owner", own4, 0);
        chk("allidle_ho", ho4, 0);
        chk("allidle_hold", u_h4.hold_cnt, 0);

        // Owner requesting alone: no count, no pulse.
        req_n = 4'b1110;
        tick();
        chk("solo_owner", own4, 0);
        chk("solo_hold", u_h4.hold_cnt, 0);
        chk("solo_ho", ho4, 0);

        // Hold limit: m1 waits from here; forced move after 4 edges.
        req_n = 4'b1100;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("hold_owner_%0d", k), own4, 0);
            chk($sformatf("hold_cnt_%0d", k), u_h4.hold_cnt, k);
            chk($sformatf("hold_ho_%0d", k), ho4, 0);
            chk($sformatf("nolim_owner_%0d", k), own0, 0);
        end
        tick();
        chk("limit_owner", own4, 1);
        chk("limit_grnt", g4, 4'b1101);
        chk("limit_ho", ho4, 1);
        chk("limit_hold", u_h4.hold_cnt, 0);
        chk("nolim_owner_4", own0, 0);
        chk("nolim_hold", u_h0.hold_cnt, 0);
        for (int k = 5; k <= 100; k++) begin
            tick();
            chk($sformatf("nolim_owner_%0d", k), own0, 0);
        end
        chk("nolim_ho_end", ho0, 0);

        // Reset in the cycle that would otherwise force a handover.
        reset = 1'b1;
        req_n = 4'hF;
        tick();
        reset = 1'b0;
        req_n = 4'b1100;
        for (int k = 1; k <= 3; k++) begin
            tick();
        end
        chk("mid_hold_cnt", u_h4.hold_cnt, 3);
        chk("mid_hold_owner", own4, 0);
        reset = 1'b1;
        tick();
        chk("mid_rst_owner", own4, 0);
        chk("mid_rst_hold", u_h4.hold_cnt, 0);
        chk("mid_rst_ho", ho4, 0);
        chk("mid_rst_grnt", g4, 4'b1110);
        reset = 1'b0;
        tick();
        chk("post_rst_owner", own4, 0);
        chk("post_rst_hold", u_h4.hold_cnt, 1);

        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
